// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state types for seq_alu_par
package alu_pkg;
  typedef enum logic [2:0] {
    OP_NEG   = 3'b000,
    OP_INC   = 3'b001,
    OP_ADC   = 3'b010,
    OP_ADDSH = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_CAT   = 3'b110,
    OP_MUL   = 3'b111
  } op_t;
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: shift-add multiplier, one iteration per edge while i_run
module seq_alu_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  // o_prod is the accumulator after the current iteration, so the final edge can register it directly
  assign o_prod = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_run) begin
      r_acc    <= o_prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seq_alu_par.sv
// seq_alu_par: registered ALU, single-cycle ops plus a WIDTH-cycle multiply
module seq_alu_par
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             ovf
);
  state_t           r_state;
  op_t              w_op;
  logic [WIDTH-1:0] w_op2;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_o;
  logic [WIDTH-1:0] w_prod;
  logic             w_last;
  logic             w_accept;
  logic             w_upd;
  logic [WIDTH-1:0] w_nxt;
  assign w_op      = op_t'(opc);
  assign w_accept  = r_state == ST_IDLE && start;
  assign w_op2     = w_op == OP_INC ? WIDTH'(1) : w_op == OP_ADDSH ? {1'b0, b[WIDTH-1:1]} : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_op == OP_ADC && cin};
  assign w_add_ovf = a[WIDTH-1] == w_op2[WIDTH-1] && w_sum[WIDTH-1] != a[WIDTH-1];
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    case (w_op)
      OP_NEG: begin
        w_res = -a;
        w_c   = a == '0;
        w_o   = a == {1'b1, {(WIDTH-1){1'b0}}};
      end
      OP_INC, OP_ADC, OP_ADDSH: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_o   = w_add_ovf;
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_CAT:  w_res = {a[WIDTH/2-1:0], b[WIDTH/2-1:0]};
      default: w_res = '0;
    endcase
  end
  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept && w_op == OP_MUL),
    .i_run  (r_state == ST_MUL),
    .i_a    (a),
    .i_b    (b),
    .o_last (w_last),
    .o_prod (w_prod)
  );
  assign w_upd = (w_accept && w_op != OP_MUL) || (r_state == ST_MUL && w_last);
  assign w_nxt = r_state == ST_MUL ? w_prod : w_res;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      w       <= '0;
      zer     <= 1'b1;
      neg     <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= w_upd;
      if (w_accept && w_op == OP_MUL) begin
        r_state <= ST_MUL;
        busy    <= 1'b1;
      end else if (r_state == ST_MUL && w_last) begin
        r_state <= ST_IDLE;
        busy    <= 1'b0;
      end
      if (w_upd) begin
        w    <= w_nxt;
        zer  <= w_nxt == '0;
        neg  <= w_nxt[WIDTH-1];
        cout <= r_state == ST_MUL ? 1'b0 : w_c;
        ovf  <= r_state == ST_MUL ? 1'b0 : w_o;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu_par.sv
// tb_seq_alu_par: directed vectors against hand-computed results, WIDTH=16
module tb_seq_alu_par;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic [2:0]  opc = '0;
  logic        busy, done, zer, neg, cout, ovf;
  logic [15:0] w;
  int n_cmp = 0;
  int n_bad = 0;
  seq_alu_par #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .opc(opc),
    .busy(busy), .done(done), .w(w), .zer(zer), .neg(neg), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic [2:0] io);
    a = ia; b = ib; cin = ic; opc = io; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic res(input string tag, input logic [15:0] ew, input logic ez, input logic en,
                     input logic ec, input logic eo);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".w"}, w, ew);
    chk({tag, ".zer"}, zer, ez);
    chk({tag, ".neg"}, neg, en);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"}, ovf, eo);
  endtask
  task automatic mul(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                     input logic [15:0] ew, input logic inj);
    int n;
    logic [15:0] w0;
    w0 = w;
    op(ia, ib, 1'b0, 3'b111);
    chk({tag, ".busy0"}, busy, 1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 5) begin
        chk({tag, ".hold_w"}, w, w0);
        chk({tag, ".no_done"}, done, 0);
      end
      start = inj && n == 3;
      if (inj && n == 3) begin
        a = 16'h0005; b = 16'h0009; opc = 3'b000;
      end else if (inj && n == 4) begin
        a = 16'h1234; b = 16'h5678;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({tag, ".busy_cycles"}, n, 16);
    res(tag, ew, ew == 0, ew[15], 1'b0, 1'b0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.w", w, 0);
    chk("rst.zer", zer, 1);
    chk("rst.flags", {neg, cout, ovf, done, busy}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    op(16'h0005, 16'h0000, 1'b0, 3'b000); res("neg5", 16'hFFFB, 0, 1, 0, 0);
    @(posedge clk); #1;
    chk("neg5.done_pulse", done, 0);
    chk("neg5.hold_w", w, 16'hFFFB);
    op(16'h0000, 16'h0000, 1'b0, 3'b000); res("neg0", 16'h0000, 1, 0, 1, 0);
    op(16'h8000, 16'h0000, 1'b0, 3'b000); res("negmin", 16'h8000, 0, 1, 0, 1);
    op(16'hFFFF, 16'h0000, 1'b1, 3'b010); res("adc_c", 16'h0000, 1, 0, 1, 0);
    op(16'h7FFF, 16'h0001, 1'b0, 3'b010); res("adc_v", 16'h8000, 0, 1, 0, 1);
    op(16'h7FFF, 16'h0000, 1'b0, 3'b001); res("inc_v", 16'h8000, 0, 1, 0, 1);
    op(16'hFFFF, 16'h0000, 1'b0, 3'b001); res("inc_c", 16'h0000, 1, 0, 1, 0);
    op(16'h0001, 16'h0005, 1'b1, 3'b011); res("addsh", 16'h0003, 0, 0, 0, 0);
    op(16'hFFFF, 16'h8002, 1'b0, 3'b011); res("addsh_c", 16'h4000, 0, 0, 1, 0);
    op(16'h12AB, 16'h34CD, 1'b0, 3'b110); res("cat", 16'hABCD, 0, 1, 0, 0);
    op(16'h00F0, 16'h0F0F, 1'b0, 3'b100); res("and", 16'h0000, 1, 0, 0, 0);
    op(16'h00F0, 16'h0F0F, 1'b0, 3'b101); res("or", 16'h0FFF, 0, 0, 0, 0);
    mul("mul7x6", 16'h0007, 16'h0006, 16'h002A, 1'b1);
    mul("mul_b2b", 16'h0100, 16'h0100, 16'h0000, 1'b0);
    mul("mul_sgn", 16'hFFFD, 16'h0005, 16'hFFF1, 1'b0);
    op(16'h0005, 16'h0000, 1'b0, 3'b000); res("pre_rst", 16'hFFFB, 0, 1, 0, 0);
    op(16'h0003, 16'h0005, 1'b0, 3'b111);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; opc = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.w", w, 0);
    chk("abort.zer", zer, 1);
    @(posedge clk); #1;
    chk("abort.quiet", {done, busy, w}, 0);
    op(16'h0005, 16'h0000, 1'b0, 3'b000); res("post_rst", 16'hFFFB, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
